// File: rtl/chain_gap_cost.sv
// Chaining gap cost: scores a (dr, dq) anchor gap through a three-stage
// valid/ready pipeline; unchainable pairs flow through flagged as rejected.
module chain_gap_cost #(
  parameter int unsigned MAX_DIST  = 5000,
  parameter int unsigned BW        = 500,
  parameter int unsigned Q_SPAN    = 15,
  parameter int unsigned SPAN_COEF = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_dr,
  input  logic [31:0] in_dq,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_score,
  output logic        out_reject
);

  localparam int unsigned W  = 32;
  localparam int unsigned LW = 5;
  localparam logic signed [W-1:0] MAX_DIST_S = W'(MAX_DIST);
  localparam logic signed [W-1:0] Q_SPAN_S   = W'(Q_SPAN);
  localparam logic        [W-1:0] BW_U       = W'(BW);
  localparam logic        [15:0]  COEF       = 16'(SPAN_COEF);
  localparam logic        [W-1:0] REJ_SCORE  = 32'h8000_0000;

  // Stage registers
  logic                s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d;
  logic [W-1:0]        s1_dd_q, s1_dd_d;
  logic signed [W-1:0] s1_min_q, s1_min_d;
  logic                s1_rej_q, s1_rej_d;
  logic [LW-1:0]       s2_log_q, s2_log_d;
  logic [W-1:0]        s2_lin_q, s2_lin_d;
  logic signed [W-1:0] s2_sc_q, s2_sc_d;
  logic                s2_rej_q, s2_rej_d;
  logic [W-1:0]        s3_score_q, s3_score_d;
  logic                s3_rej_q, s3_rej_d;

  logic         s1_rdy_c, s2_rdy_c, s3_rdy_c;
  logic [W:0]   diff_c, mag_c;
  logic [W-1:0] dd_c, gap_c;
  logic [LW-1:0] log_c;

  // A stage loads when empty or when its occupant moves on this cycle
  assign s3_rdy_c = !s3_v_q || out_ready;
  assign s2_rdy_c = !s2_v_q || s3_rdy_c;
  assign s1_rdy_c = !s1_v_q || s2_rdy_c;
  assign in_ready = !rst && s1_rdy_c;

  // Sign-extended difference; its magnitude always fits 32 bits, saturate anyway
  assign diff_c = {in_dr[W-1], in_dr} - {in_dq[W-1], in_dq};
  assign mag_c  = diff_c[W] ? (~diff_c + 1'b1) : diff_c;
  assign dd_c   = mag_c[W] ? '1 : mag_c[W-1:0];

  // Leading-one position; stays 0 for dd = 0
  always_comb begin
    log_c = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (s1_dd_q[i]) log_c = LW'(i);
    end
  end

  assign gap_c = s2_lin_q + W'(s2_log_q >> 1);

  always_comb begin
    s1_v_d     = s1_v_q;
    s1_dd_d    = s1_dd_q;
    s1_min_d   = s1_min_q;
    s1_rej_d   = s1_rej_q;
    s2_v_d     = s2_v_q;
    s2_log_d   = s2_log_q;
    s2_lin_d   = s2_lin_q;
    s2_sc_d    = s2_sc_q;
    s2_rej_d   = s2_rej_q;
    s3_v_d     = s3_v_q;
    s3_score_d = s3_score_q;
    s3_rej_d   = s3_rej_q;

    if (s1_rdy_c) begin
      s1_v_d   = in_valid;
      s1_dd_d  = dd_c;
      s1_min_d = ($signed(in_dr) < $signed(in_dq)) ? $signed(in_dr) : $signed(in_dq);
      s1_rej_d = ($signed(in_dq) <= 0) || ($signed(in_dq) > MAX_DIST_S) ||
                 ($signed(in_dr) <= 0) || (dd_c > BW_U);
    end

    if (s2_rdy_c) begin
      s2_v_d   = s1_v_q;
      s2_log_d = log_c;
      s2_lin_d = (W'(s1_dd_q[15:0]) * W'(COEF)) >> 8;
      s2_sc_d  = (s1_min_q < Q_SPAN_S) ? s1_min_q : Q_SPAN_S;
      s2_rej_d = s1_rej_q;
    end

    if (s3_rdy_c) begin
      s3_v_d     = s2_v_q;
      s3_rej_d   = s2_rej_q;
      s3_score_d = s2_rej_q ? REJ_SCORE : ($unsigned(s2_sc_q) - gap_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_dd_q    <= '0;
      s1_min_q   <= '0;
      s1_rej_q   <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_log_q   <= '0;
      s2_lin_q   <= '0;
      s2_sc_q    <= '0;
      s2_rej_q   <= 1'b0;
      s3_v_q     <= 1'b0;
      s3_score_q <= '0;
      s3_rej_q   <= 1'b0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_dd_q    <= s1_dd_d;
      s1_min_q   <= s1_min_d;
      s1_rej_q   <= s1_rej_d;
      s2_v_q     <= s2_v_d;
      s2_log_q   <= s2_log_d;
      s2_lin_q   <= s2_lin_d;
      s2_sc_q    <= s2_sc_d;
      s2_rej_q   <= s2_rej_d;
      s3_v_q     <= s3_v_d;
      s3_score_q <= s3_score_d;
      s3_rej_q   <= s3_rej_d;
    end
  end

  assign out_valid  = s3_v_q;
  assign out_score  = s3_score_q;
  assign out_reject = s3_rej_q;

endmodule

// File: tb/tb_chain_gap_cost.sv
// Bench for chain_gap_cost: a scoreboard fed on every input transfer and
// drained on every output transfer, plus per-scenario handshake checks.
module tb_chain_gap_cost;

  localparam longint MAXD = 5000;
  localparam longint BWD  = 500;
  localparam longint QS   = 15;
  localparam longint COEF = 64;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, out_reject;
  logic [31:0] in_dr, in_dq, out_score;

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] sb[$];
  logic        stall_hold = 1'b0;
  logic [32:0] held;
  bit          rnd_mode = 1'b0;

  logic [31:0] sdr[5] = '{32'd100, 32'd110, 32'd600, 32'd700, 32'd50};
  logic [31:0] sdq[5] = '{32'd100, 32'd100, 32'd100, 32'd100, 32'd52};

  chain_gap_cost dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_dr(in_dr), .in_dq(in_dq), .out_valid(out_valid), .out_ready(out_ready),
    .out_score(out_score), .out_reject(out_reject)
  );

  always #5 clk = ~clk;

  // Reference model: {reject, score}
  function automatic logic [32:0] model(input logic [31:0] dr_u, input logic [31:0] dq_u);
    longint dr, dq, dd, t, lg, lin, sc, s;
    dr = longint'($signed(dr_u));
    dq = longint'($signed(dq_u));
    dd = dr - dq;
    if (dd < 0) dd = -dd;
    if (dq <= 0 || dq > MAXD || dr <= 0 || dd > BWD) return {1'b1, 32'h8000_0000};
    lg = 0;
    t = dd;
    while (t > 1) begin t = t >> 1; lg++; end
    lin = ((dd & 64'hFFFF) * COEF) / 256;
    sc = (dr < dq) ? dr : dq;
    if (sc > QS) sc = QS;
    s = sc - (lin + lg / 2);
    return {1'b0, 32'(s)};
  endfunction

  // Monitor: transfers happen at the posedge following this sample
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      stall_hold = 1'b0;
    end else begin
      if (stall_hold) begin
        n_vec++;
        if (out_valid !== 1'b1 || {out_reject, out_score} !== held) begin
          n_err++;
          $display("FAIL stall_stable: got v=%b %h, held %h", out_valid, {out_reject, out_score}, held);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: got rej=%b score=%0d with nothing expected", out_reject, $signed(out_score));
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          if ({out_reject, out_score} !== e) begin
            n_err++;
            $display("FAIL result: got rej=%b score=%0d, need rej=%b score=%0d",
                     out_reject, $signed(out_score), e[32], $signed(e[31:0]));
          end
        end
      end
      stall_hold = (out_valid === 1'b1 && out_ready === 1'b0);
      held = {out_reject, out_score};
      if (in_valid === 1'b1 && in_ready === 1'b1) sb.push_back(model(in_dr, in_dq));
    end
  end

  task automatic send(input logic [31:0] dr, input logic [31:0] dq);
    bit acc;
    int t;
    in_valid = 1'b1;
    in_dr = dr;
    in_dq = dq;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 50) begin
      if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = (in_ready === 1'b1);
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_ready never high, need 1");
    end
  endtask

  task automatic drain();
    int t;
    out_ready = 1'b1;
    in_valid = 1'b0;
    t = 0;
    while ((sb.size() != 0 || out_valid === 1'b1) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results outstanding, need 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b need 0", in_ready); end
    n_vec++;
    if (out_valid !== 1'b0 || out_reject !== 1'b0 || out_score !== 32'd0) begin
      n_err++;
      $display("FAIL reset_out: got v=%b rej=%b score=%h need 0 0 0", out_valid, out_reject, out_score);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b need 1", in_ready); end
  endtask

  task automatic test_latency();
    int cyc;
    out_ready = 1'b1;
    in_valid = 1'b1; in_dr = 32'd100; in_dq = 32'd100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (cyc !== 3 || out_score !== 32'd15 || out_reject !== 1'b0) begin
      n_err++;
      $display("FAIL latency: got %0d cycles score=%0d rej=%b, need 3 cycles score=15 rej=0",
               cyc, $signed(out_score), out_reject);
    end
    drain();
  endtask

  // Back-to-back directed vectors with out_ready high: one per cycle, no bubbles
  task automatic test_directed();
    logic [31:0] vdr[12] = '{100, 110, 100, 100, 700, 600, 5000, 5001, 601, 0, 3, 100};
    logic [31:0] vdq[12] = '{100, 100, 0, 5001, 100, 100, 5000, 5001, 100, 10, 5, 600};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_dr = vdr[i]; in_dq = vdq[i];
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL throughput_ready[%0d]: got %b need 1", i, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_stall();
    int k;
    bit acc, exp_r;
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 11; c++) begin
      if (c == 6) out_ready = 1'b1;
      if (k < 5) begin in_valid = 1'b1; in_dr = sdr[k]; in_dq = sdq[k]; end
      else in_valid = 1'b0;
      #1;
      exp_r = (c < 3) || (c >= 6);
      n_vec++;
      if (in_ready !== exp_r) begin n_err++; $display("FAIL stall_ready[c%0d]: got %b need %b", c, in_ready, exp_r); end
      if (c >= 6) begin
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL release_stream[c%0d]: out_valid %b need 1", c, out_valid); end
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) k++;
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_flight();
    out_ready = 1'b1;
    in_valid = 1'b1; in_dr = 32'd100; in_dq = 32'd100;
    @(posedge clk); #1;
    in_dr = 32'd110;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL flight_rst_ready: got %b need 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_reject !== 1'b0 || out_score !== 32'd0) begin
      n_err++;
      $display("FAIL flight_rst_out: got v=%b rej=%b score=%h need 0 0 0", out_valid, out_reject, out_score);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL flight_release_ready: got %b need 1", in_ready); end
    in_valid = 1'b1; in_dr = 32'd3; in_dq = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_random();
    int dr, dq;
    rnd_mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      dr = int'($urandom_range(0, 1200)) - 100;
      dq = dr + int'($urandom_range(0, 1100)) - 550;
      if ($urandom_range(0, 7) == 0) begin
        dq = 4990 + int'($urandom_range(0, 20));
        dr = dq + int'($urandom_range(0, 40)) - 20;
      end
      send(32'(dr), 32'(dq));
      if ($urandom_range(0, 3) == 0) begin
        out_ready = ($urandom_range(0, 1) != 0);
        @(posedge clk); #1;
      end
    end
    rnd_mode = 1'b0;
    drain();
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; in_dr = '0; in_dq = '0; out_ready = 1'b1;
    test_reset();
    test_latency();
    test_directed();
    test_stall();
    test_reset_flight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
